// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks fetched PCs with their BTB predictions in order and
// checks them at resolve time. Optional BRU_STATS_EN adds branch/mispredict counters.
module branch_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [63:0] fetch_pc,
  input  logic [63:0] fetch_pred_pc,
  input  logic        resolve_valid,
  output logic        resolve_ready,
  input  logic        resolve_is_branch,
  input  logic        resolve_taken,
  input  logic [63:0] resolve_target,
  output logic        flush,
  output logic [63:0] redirect_pc,
  output logic        btb_en,
  output logic [63:0] btb_prev_pc,
  output logic [63:0] btb_branch_pc,
  output logic        btb_was_taken
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  state_t state_reg, state_next;

  logic [63:0] pc_mem   [DEPTH];
  logic [63:0] pred_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic        push, pop, mispredict;
  logic [63:0] entry_pc, entry_pred, pc_plus4, actual_next, pred_next;

  assign fetch_ready   = (state_reg == RUN) && (count_reg != FULL_COUNT);
  assign resolve_ready = (state_reg == RUN) && (count_reg != '0);

  assign push = fetch_valid & fetch_ready;
  assign pop  = resolve_valid & resolve_ready;

  assign entry_pc    = pc_mem[rd_ptr_reg];
  assign entry_pred  = pred_mem[rd_ptr_reg];
  assign pc_plus4    = entry_pc + 64'd4;
  assign actual_next = (resolve_is_branch & resolve_taken) ? resolve_target : pc_plus4;
  // A zero stored prediction means the BTB had no entry, so fall-through is assumed.
  assign pred_next   = (entry_pred != 64'd0) ? entry_pred : pc_plus4;
  assign mispredict  = pop && (actual_next != pred_next);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_reg <= RUN;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (mispredict) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Storage carries no reset; validity is tracked purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= fetch_pc;
      pred_mem[wr_ptr_reg] <= fetch_pred_pc;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (mispredict) begin
      // Everything younger than the mispredicted instruction is wrong-path, including a same-cycle push.
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      flush         <= 1'b0;
      redirect_pc   <= 64'd0;
      btb_en        <= 1'b0;
      btb_prev_pc   <= 64'd0;
      btb_branch_pc <= 64'd0;
      btb_was_taken <= 1'b0;
    end else begin
      flush  <= mispredict;
      btb_en <= pop & resolve_is_branch;
      if (mispredict) redirect_pc <= actual_next;
      if (pop) begin
        btb_prev_pc   <= entry_pc;
        btb_branch_pc <= resolve_target;
        btb_was_taken <= resolve_taken & resolve_is_branch;
      end
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (pop && resolve_is_branch && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic
// against a queue-based reference model. Build with +define+BRU_STATS_EN to cover the counters.
module tb_branch_resolve_unit;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        fetch_valid, fetch_ready;
  logic [63:0] fetch_pc, fetch_pred_pc;
  logic        resolve_valid, resolve_ready, resolve_is_branch, resolve_taken;
  logic [63:0] resolve_target;
  logic        flush, btb_en, btb_was_taken;
  logic [63:0] redirect_pc, btb_prev_pc, btb_branch_pc;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk), .arst_n(arst_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_pred_pc(fetch_pred_pc),
    .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
    .resolve_is_branch(resolve_is_branch), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .btb_en(btb_en), .btb_prev_pc(btb_prev_pc),
    .btb_branch_pc(btb_branch_pc), .btb_was_taken(btb_was_taken)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] pred;
  } ent_t;

  ent_t        q[$];
  logic        in_flush;
  logic        exp_flush, exp_btb_en, exp_taken;
  logic [63:0] exp_redirect, exp_prev, exp_branch;
  logic [31:0] exp_stat_b, exp_stat_m;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    in_flush = 0; exp_flush = 0; exp_btb_en = 0; exp_taken = 0;
    exp_redirect = 0; exp_prev = 0; exp_branch = 0;
    exp_stat_b = 0; exp_stat_m = 0;
  endtask

  task automatic check_regs();
    check_eq("flush", flush, exp_flush);
    check_eq("redirect_pc", redirect_pc, exp_redirect);
    check_eq("btb_en", btb_en, exp_btb_en);
    check_eq("btb_prev_pc", btb_prev_pc, exp_prev);
    check_eq("btb_branch_pc", btb_branch_pc, exp_branch);
    check_eq("btb_was_taken", btb_was_taken, exp_taken);
`ifdef BRU_STATS_EN
    check_eq("stat_branches", stat_branches, exp_stat_b);
    check_eq("stat_mispredicts", stat_mispredicts, exp_stat_m);
`endif
  endtask

  // One clock of traffic; called just after an active edge.
  task automatic step(input logic fv, input logic [63:0] pc, input logic [63:0] pred,
                      input logic rv, input logic br, input logic tk, input logic [63:0] tgt);
    logic efr, err_r, push, pop, mis;
    logic [63:0] p4, act, prd;
    ent_t e;
    efr   = !in_flush && (q.size() < DEPTH);
    err_r = !in_flush && (q.size() > 0);
    fetch_valid = fv; fetch_pc = pc; fetch_pred_pc = pred;
    resolve_valid = rv; resolve_is_branch = br; resolve_taken = tk; resolve_target = tgt;
    #1;
    check_eq("fetch_ready", fetch_ready, efr);
    check_eq("resolve_ready", resolve_ready, err_r);
    push = fv && efr;
    pop  = rv && err_r;
    mis = 0; exp_flush = 0; exp_btb_en = 0;
    if (pop) begin
      e   = q.pop_front();
      p4  = e.pc + 64'd4;
      act = (br && tk) ? tgt : p4;
      prd = (e.pred != 0) ? e.pred : p4;
      mis = (act != prd);
      exp_btb_en = br;
      exp_prev = e.pc; exp_branch = tgt; exp_taken = br && tk;
      if (br && exp_stat_b != 32'hFFFF_FFFF) exp_stat_b++;
      if (mis) begin
        exp_flush = 1; exp_redirect = act;
        if (exp_stat_m != 32'hFFFF_FFFF) exp_stat_m++;
      end
    end
    if (mis) q.delete();
    else if (push) q.push_back('{pc, pred});
    in_flush = mis;
    @(posedge clk); #1;
    check_regs();
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    fetch_valid = 0; resolve_valid = 0; resolve_is_branch = 0; resolve_taken = 0;
    fetch_pc = 0; fetch_pred_pc = 0; resolve_target = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_regs();
    arst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] pc_n, tgt;
    logic br, tk;
    do_reset();
    // Idle with resolve_valid on an empty FIFO.
    step(0, 0, 0, 1, 1, 1, 64'h55);
    // Correct taken prediction.
    step(1, 64'h1000, 64'h2000, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 64'h2000);
    // Missed taken branch, then FLUSH cycle and RUN again.
    step(1, 64'h1000, 0, 0, 0, 0, 0);
    step(1, 64'h1004, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 64'h3000);
    step(1, 64'h3000, 0, 1, 0, 0, 0);
    step(1, 64'h3000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    // Predicted taken but not taken.
    step(1, 64'h40, 64'h80, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 64'h80);
    step(0, 0, 0, 0, 0, 0, 0);
    // Fill, overfill, then pop+push across the pointer wrap.
    pc_n = 64'h8000;
    for (int i = 0; i < 9; i++) begin
      step(1, pc_n, pc_n + 64'h100, 0, 0, 0, 0);
      pc_n += 4;
    end
    for (int i = 0; i < 10; i++) begin
      tgt = q[0].pred;
      step(1, pc_n, pc_n + 64'h100, 1, 1, 1, tgt);
      pc_n += 4;
    end
    // Non-branch with a stale prediction, pushed alongside the mispredicting pop.
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 1, 1, q[0].pred);
    step(1, 64'h500, 64'h900, 0, 0, 0, 0);
    step(1, 64'h600, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      pc_n = {32'h0, $urandom} & ~64'h3;
      br = ($urandom_range(0, 1) == 1);
      tk = ($urandom_range(0, 1) == 1);
      tgt = {32'h0, $urandom} & ~64'h3;
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        tgt = (q[0].pred != 0) ? q[0].pred : q[0].pc + 64'd4;
      step($urandom_range(0, 9) < 7, pc_n,
           ($urandom_range(0, 2) == 0) ? 64'd0 : ({32'h0, $urandom} & ~64'h3),
           $urandom_range(0, 9) < 6, br, tk, tgt);
      if (i == 300) do_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
